colour_pwm_driver: RTL and testbench
====================================

// Module: colour_pwm_driver
// PURPOSE
//  Receiving end of the 3-bit colour bus produced by the button-driven LED colour sequencer.
//  Decodes colour[2:0] into three PWM LED drives (red, green, blue).
//  On every colour change, each channel's brightness fades between levels over several PWM periods.
//  Sits between the sequencer and the board RGB LED pins.
// PARAMETERS
//  PWM_W      4   PWM counter width; PWM period = 2**PWM_W clk cycles
//  STEP       4   duty change per PWM period while fading; 1..2**PWM_W
// PORTS
//  clk        in   1    system clock, rising edge
//  rst        in   1    synchronous, active-high reset
//  colour     in   3    colour code from the sequencer: bit2=red, bit1=green, bit0=blue
//  red        out  1    red LED PWM drive
//  green      out  1    green LED PWM drive
//  blue       out  1    blue LED PWM drive
//  fading     out  1    high while any channel duty differs from its target
//  err        out  1    high while the registered colour is an invalid code (000 or 111)
// BEHAVIOUR
//  Reset (rst=1 at a rising edge) sets the following, overriding all else and aborting any fade:
//   colour_q=0, cnt=0, duty_r/g/b=0, red=green=blue=0, fading=0, err=0.
//  Input capture: every edge colour_q<=colour and err<=(colour==3'b000 || colour==3'b111).
//   err therefore has 1-cycle latency.
//  Targets (derived from colour_q):
//   Valid codes 001..110: each channel's target = 2**PWM_W if its bit is 1, else 0.
//   Invalid codes (000, 111): all targets = 0, i.e. LEDs fade to off.
//  cnt is a free-running PWM_W-bit counter that wraps 2**PWM_W-1 -> 0.
//   Define wrap = (cnt == 2**PWM_W-1).
//  Duty registers are PWM_W+1 bits wide, range 0..2**PWM_W; 2**PWM_W means always on.
//   Duty changes only at a wrap edge.
//   At a wrap edge, duty moves toward its target by min(STEP, |target-duty|).
//   Duty saturates at the target: no overshoot, no wrap-around.
//  Outputs are registered. Every edge: red <= (cnt < duty_r), same form for green and blue.
//   duty=0 gives an output that stays low; duty=2**PWM_W gives an output that stays high.
//  fading <= (any duty_x != target_x), evaluated every edge.
//  Channel state per channel: STEADY (duty==target) / RAMP_UP / RAMP_DOWN.
//   The state is re-evaluated every cycle from duty and target.
//  A colour change mid-fade retargets immediately. The fade continues from the current duty.
//   There is no restart and no glitch to 0.
//  Colour changes that do not align with a wrap are simply sampled; cnt is never reset by a colour change.
// CONFIGURATION
//  Macro COLOUR_PWM_FADE_EN.
//   Defined: fade as described above.
//   Undefined: STEP is ignored. At the first wrap edge after a target change, duty is loaded with the target directly.
//    fading is high only from the target change until that wrap edge.
// STRUCTURE
//  Package colour_pkg holds:
//   localparams COL_OFF=3'b000, COL_WHITE=3'b111.
//   Bit indices R_BIT=2, G_BIT=1, B_BIT=0.
//   Function colour_invalid(code).
//  Sub-module pwm_channel, instantiated 3x. It contains the duty register, the ramp logic and the comparator.
//   Inputs: target and wrap, plus cnt.
//   Outputs: pwm and busy.
//  Top level contains colour_q, cnt, err, the target decode and the OR of busy to form fading.
// TESTING (PWM_W=4, STEP=4; 1 period = 16 cycles)
//  rst=1 for 2 cycles with colour=3'b101 -> red=green=blue=0, fading=0, err=0, cnt=0 on the first edge after reset.
//  colour=3'b001 held, FADE_EN defined -> blue duty 4,8,12,16 over 4 wraps.
//   Blue high for 4,8,12 cycles per period, then stays high.
//   fading drops at the edge after duty reaches 16. red=green=0 throughout.
//  From steady 001, colour=3'b000 -> err=1 one cycle later.
//   Blue duty 16->12->8->4->0 at wraps, then blue stays low. Returning to 010 clears err one cycle after the change.
//  Mid-fade retarget: 001 held until blue duty=8, then colour=3'b110.
//   Blue ramps 8->4->0 while red and green ramp 0->4->...->16 in parallel. No channel ever jumps.
//  FADE_EN undefined, colour 001->110 -> at the first wrap, duty_b=0 and duty_r=duty_g=16.
//   fading is low from the edge after that wrap.
//  rst asserted mid-fade (duty=8) -> all outputs and duties 0 at that edge.
//   After release, the fade restarts from 0 toward the current target.

Source files
------------

// File: rtl/colour_pkg.sv
// -----------------------------------------------------------------------------
// colour_pkg
//   Shared definitions for the RGB colour PWM driver: the two colour codes the
//   sequencer never legitimately produces, the bit position of each LED
//   channel inside the 3-bit colour code, the per-channel ramp state, and the
//   invalid-code helper.
// -----------------------------------------------------------------------------
package colour_pkg;

    // Codes that carry no colour: all LEDs off and all LEDs on.
    localparam logic [2:0] COL_OFF   = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

    // Bit positions of each channel in the colour code.
    localparam int R_BIT = 2;
    localparam int G_BIT = 1;
    localparam int B_BIT = 0;

    // Per-channel ramp state, derived each cycle from duty versus target.
    typedef enum logic [1:0] {
        CH_STEADY    = 2'd0,
        CH_RAMP_UP   = 2'd1,
        CH_RAMP_DOWN = 2'd2
    } ch_state_t;

    // 000 and 111 are treated as invalid: the LEDs fade to off.
    function automatic logic colour_invalid(input logic [2:0] code);
        return (code == COL_OFF) || (code == COL_WHITE);
    endfunction

endpackage : colour_pkg

// File: rtl/colour_pwm_driver_pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
//   One LED channel: a duty register that walks toward its target once per
//   PWM period, plus the registered PWM comparator.
//
//   Build option: COLOUR_PWM_FADE_EN
//     defined   - duty moves by at most STEP per PWM period (soft fade)
//     undefined - duty is loaded with the target at the next wrap
//
//   Ports
//     clk     in   1        system clock, rising edge
//     rst     in   1        synchronous active-high reset
//     target  in   PWM_W+1  wanted duty, 0..2**PWM_W
//     wrap    in   1        high on the last cycle of a PWM period
//     cnt     in   PWM_W    shared free-running PWM counter
//     pwm     out  1        registered PWM drive
//     busy    out  1        duty has not yet reached target
// -----------------------------------------------------------------------------
module pwm_channel
    import colour_pkg::*;
#(
    parameter int PWM_W = 4,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W:0]   target,
    input  logic             wrap,
    input  logic [PWM_W-1:0] cnt,
    output logic             pwm,
    output logic             busy
);

    localparam logic [PWM_W:0] FULL = {1'b1, {PWM_W{1'b0}}};

`ifdef COLOUR_PWM_FADE_EN
    localparam logic [PWM_W:0] STEP_V = (PWM_W+1)'(STEP);
`else
    // A full-scale step always lands on the target in one wrap, which is the
    // hard-switch behaviour; STEP plays no part in this build.
    localparam logic [PWM_W:0] STEP_V = FULL;
`endif

    logic [PWM_W:0] duty;
    ch_state_t      state;

    // Move one step toward the target, clamping at the target so the duty
    // can neither overshoot nor wrap around through 0 / 2**PWM_W.
    function automatic logic [PWM_W:0] ramp_step(input logic [PWM_W:0] cur,
                                                 input logic [PWM_W:0] tgt,
                                                 input ch_state_t      st);
        logic [PWM_W:0] gap;
        gap       = '0;
        ramp_step = tgt;
        case (st)
            CH_RAMP_UP: begin
                gap = tgt - cur;
                if (gap > STEP_V) ramp_step = cur + STEP_V;
            end
            CH_RAMP_DOWN: begin
                gap = cur - tgt;
                if (gap > STEP_V) ramp_step = cur - STEP_V;
            end
            default: ramp_step = cur;
        endcase
    endfunction

    // Ramp direction is re-derived every cycle, so a retarget mid-fade simply
    // continues from the present duty.
    always_comb begin
        state = CH_STEADY;
        if (duty > target)
            state = CH_RAMP_DOWN;
        else if (duty < target)
            state = CH_RAMP_UP;
    end

    assign busy = (state != CH_STEADY);

    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            // Duty only changes between periods so no period is ever cut short.
            if (wrap)
                duty <= ramp_step(duty, target, state);
            // Widened compare: duty == 2**PWM_W keeps the output high all period.
            pwm <= ({1'b0, cnt} < duty);
        end
    end

endmodule : pwm_channel

// File: rtl/colour_pwm_driver.sv
// -----------------------------------------------------------------------------
// colour_pwm_driver
//   Receives the 3-bit colour code from the LED colour sequencer and drives
//   the three board RGB LED pins with PWM, fading each channel between levels
//   whenever the colour changes.
//
//   Build option: COLOUR_PWM_FADE_EN (see pwm_channel). With it undefined the
//   channels switch to the new level at the first PWM wrap after a change.
//
//   Ports
//     clk     in   1   system clock, rising edge
//     rst     in   1   synchronous active-high reset
//     colour  in   3   colour code: bit2 red, bit1 green, bit0 blue
//     red     out  1   red LED PWM drive
//     green   out  1   green LED PWM drive
//     blue    out  1   blue LED PWM drive
//     fading  out  1   some channel duty still differs from its target
//     err     out  1   registered colour code is 000 or 111
// -----------------------------------------------------------------------------
module colour_pwm_driver
    import colour_pkg::*;
#(
    parameter int PWM_W = 4,
    parameter int STEP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] colour,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       fading,
    output logic       err
);

    localparam logic [PWM_W:0]   FULL    = {1'b1, {PWM_W{1'b0}}};
    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    logic [2:0]       colour_q;
    logic [PWM_W-1:0] cnt;
    logic             wrap;
    logic [PWM_W:0]   tgt_r;
    logic [PWM_W:0]   tgt_g;
    logic [PWM_W:0]   tgt_b;
    logic             busy_r;
    logic             busy_g;
    logic             busy_b;

    assign wrap = (cnt == CNT_MAX);

    // Invalid codes force every target to 0 so the LEDs fade out.
    always_comb begin
        tgt_r = '0;
        tgt_g = '0;
        tgt_b = '0;
        if (!colour_invalid(colour_q)) begin
            if (colour_q[R_BIT]) tgt_r = FULL;
            if (colour_q[G_BIT]) tgt_g = FULL;
            if (colour_q[B_BIT]) tgt_b = FULL;
        end
    end

    // The counter is never disturbed by a colour change; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            colour_q <= COL_OFF;
            cnt      <= '0;
            err      <= 1'b0;
            fading   <= 1'b0;
        end else begin
            colour_q <= colour;
            cnt      <= cnt + PWM_W'(1);
            err      <= colour_invalid(colour);
            fading   <= busy_r | busy_g | busy_b;
        end
    end

    pwm_channel #(.PWM_W(PWM_W), .STEP(STEP)) u_red (
        .clk    (clk),
        .rst    (rst),
        .target (tgt_r),
        .wrap   (wrap),
        .cnt    (cnt),
        .pwm    (red),
        .busy   (busy_r)
    );

    pwm_channel #(.PWM_W(PWM_W), .STEP(STEP)) u_green (
        .clk    (clk),
        .rst    (rst),
        .target (tgt_g),
        .wrap   (wrap),
        .cnt    (cnt),
        .pwm    (green),
        .busy   (busy_g)
    );

    pwm_channel #(.PWM_W(PWM_W), .STEP(STEP)) u_blue (
        .clk    (clk),
        .rst    (rst),
        .target (tgt_b),
        .wrap   (wrap),
        .cnt    (cnt),
        .pwm    (blue),
        .busy   (busy_b)
    );

endmodule : colour_pwm_driver

// File: tb/tb_colour_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_colour_pwm_driver
//   Table-driven bench for colour_pwm_driver (PWM_W=4, STEP=4). Each table row
//   covers one 16-cycle PWM period: the colour applied right after a wrap, the
//   expected number of high cycles per channel in that period (equal to the
//   duty latched at the preceding wrap), err one cycle after the colour is
//   applied, and fading at the end of the period.
// -----------------------------------------------------------------------------
module tb_colour_pwm_driver;

    logic       clk;
    logic       rst;
    logic [2:0] colour;
    logic       red;
    logic       green;
    logic       blue;
    logic       fading;
    logic       err;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [2:0] colour;
        int         r;
        int         g;
        int         b;
        logic       f;
        logic       e;
    } vec_t;

    vec_t vecs[$];

    colour_pwm_driver #(.PWM_W(4), .STEP(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .colour (colour),
        .red    (red),
        .green  (green),
        .blue   (blue),
        .fading (fading),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_int(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Called at the negedge following a wrap (or reset) edge.
    task automatic run_period(input string tag, input logic [2:0] col,
                              input int er, input int eg, input int eb,
                              input logic ef, input logic ee);
        int cr;
        int cg;
        int cb;
        cr = 0;
        cg = 0;
        cb = 0;
        colour = col;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            cr += int'(red);
            cg += int'(green);
            cb += int'(blue);
            if (i == 0) check_int({tag, " err"}, int'(err), int'(ee));
        end
        check_int({tag, " red_high"},   cr, er);
        check_int({tag, " green_high"}, cg, eg);
        check_int({tag, " blue_high"},  cb, eb);
        check_int({tag, " fading"},     int'(fading), int'(ef));
    endtask

    task automatic check_all_low(input string tag);
        check_int({tag, " red"},    int'(red),    0);
        check_int({tag, " green"},  int'(green),  0);
        check_int({tag, " blue"},   int'(blue),   0);
        check_int({tag, " fading"}, int'(fading), 0);
        check_int({tag, " err"},    int'(err),    0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

`ifdef COLOUR_PWM_FADE_EN
        //                 col    r   g   b  fading err
        vecs.push_back('{3'b001,  0,  0,  0, 1'b1, 1'b0});
        vecs.push_back('{3'b001,  0,  0,  4, 1'b1, 1'b0});
        vecs.push_back('{3'b001,  0,  0,  8, 1'b1, 1'b0});
        vecs.push_back('{3'b001,  0,  0, 12, 1'b1, 1'b0});
        vecs.push_back('{3'b001,  0,  0, 16, 1'b0, 1'b0});
        vecs.push_back('{3'b000,  0,  0, 16, 1'b1, 1'b1});
        vecs.push_back('{3'b000,  0,  0, 12, 1'b1, 1'b1});
        vecs.push_back('{3'b000,  0,  0,  8, 1'b1, 1'b1});
        vecs.push_back('{3'b000,  0,  0,  4, 1'b1, 1'b1});
        vecs.push_back('{3'b010,  0,  0,  0, 1'b1, 1'b0});
        vecs.push_back('{3'b010,  0,  4,  0, 1'b1, 1'b0});
        vecs.push_back('{3'b101,  0,  8,  0, 1'b1, 1'b0});
        vecs.push_back('{3'b101,  4,  4,  4, 1'b1, 1'b0});
        vecs.push_back('{3'b101,  8,  0,  8, 1'b1, 1'b0});
        vecs.push_back('{3'b111, 12,  0, 12, 1'b1, 1'b1});
        vecs.push_back('{3'b111,  8,  0,  8, 1'b1, 1'b1});
        vecs.push_back('{3'b100,  4,  0,  4, 1'b1, 1'b0});
        vecs.push_back('{3'b100,  8,  0,  0, 1'b1, 1'b0});
        vecs.push_back('{3'b100, 12,  0,  0, 1'b1, 1'b0});
        vecs.push_back('{3'b100, 16,  0,  0, 1'b0, 1'b0});
`else
        vecs.push_back('{3'b001,  0,  0,  0, 1'b1, 1'b0});
        vecs.push_back('{3'b001,  0,  0, 16, 1'b0, 1'b0});
        vecs.push_back('{3'b110,  0,  0, 16, 1'b1, 1'b0});
        vecs.push_back('{3'b110, 16, 16,  0, 1'b0, 1'b0});
        vecs.push_back('{3'b000, 16, 16,  0, 1'b1, 1'b1});
        vecs.push_back('{3'b000,  0,  0,  0, 1'b0, 1'b1});
        vecs.push_back('{3'b111,  0,  0,  0, 1'b0, 1'b1});
        vecs.push_back('{3'b011,  0,  0,  0, 1'b1, 1'b0});
        vecs.push_back('{3'b011,  0, 16, 16, 1'b0, 1'b0});
        vecs.push_back('{3'b100,  0, 16, 16, 1'b1, 1'b0});
        vecs.push_back('{3'b100, 16,  0,  0, 1'b0, 1'b0});
`endif

        // Reset for two edges with a valid colour present on the bus.
        rst    = 1'b1;
        colour = 3'b101;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_low("reset");

        foreach (vecs[k])
            run_period($sformatf("vec%0d", k), vecs[k].colour,
                       vecs[k].r, vecs[k].g, vecs[k].b, vecs[k].f, vecs[k].e);

        // Reset landing mid-period while green is fading up.
        colour = 3'b010;
        repeat (39) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_low("midfade_reset");
        rst = 1'b0;
        run_period("post_reset0", 3'b010, 0, 0, 0, 1'b1, 1'b0);
`ifdef COLOUR_PWM_FADE_EN
        run_period("post_reset1", 3'b010, 0, 4, 0, 1'b1, 1'b0);
`else
        run_period("post_reset1", 3'b010, 0, 16, 0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule : tb_colour_pwm_driver
